// File: rtl/kbd_ps2_port.sv
// PS/2 keyboard receiver with scan-code FIFO and status/data registers on the shared
// address/data bus. The data bus is driven only while this port is being read.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling ps2_clk with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then push the byte or flag a frame error
module kbd_ps2_port #(
    parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_0000_2000,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          FILTER_LEN     = 4,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [63:0] address,
    input  logic        read,
    inout  wire  [63:0] data
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_next;
    logic [1:0]      clk_sync, dat_sync;
    logic            clk_s, data_s;
    logic            clk_filt, filt_flip, fall;
    logic [FW-1:0]   filt_cnt;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt;
    logic            par_bit;
    logic [TW-1:0]   tmr;
    logic            timeout_hit, frame_ok, frame_bad;
    logic            push_q;
    logic [7:0]      push_byte;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, not_empty, do_push, pop, clear;
    logic            overflow, frame_err;
    logic            read_q, first, hit_status, hit_data;
    logic [7:0]      head_byte, held_byte;
    logic [63:0]     status_word, data_word;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = dat_sync[1];

    // filtered clock flips only after FILTER_LEN consecutive samples disagree with it
    assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip & clk_filt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign timeout_hit = (state != IDLE) && !fall && (tmr == TW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_s) state_next = DATA;
            end
            DATA: begin
                if (timeout_hit)                   state_next = IDLE;
                else if (fall && bit_cnt == 3'd7)  state_next = PARITY;
            end
            PARITY: begin
                if (timeout_hit) state_next = IDLE;
                else if (fall)   state_next = STOP;
            end
            STOP: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (fall) begin
                    state_next = IDLE;
                    if (data_s && (^{shift, par_bit})) frame_ok  = 1'b1;
                    else                               frame_bad = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            tmr       <= '0;
            push_q    <= 1'b0;
            push_byte <= '0;
        end else begin
            push_q <= frame_ok;
            if (frame_ok) push_byte <= shift;
            if (state_next == IDLE) tmr <= '0;
            else if (fall)          tmr <= TW'(TIMEOUT_CYCLES);
            else                    tmr <= tmr - TW'(1);
            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= data_s;
                    default: ;
                endcase
            end
        end
    end

    assign hit_status = read && (address == BASE_ADDR);
    assign hit_data   = read && (address == BASE_ADDR + 64'd8);
    assign first      = read && !read_q;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign not_empty  = (count != '0);
    assign pop        = hit_data && first && not_empty;
    assign clear      = hit_status && first;
    assign do_push    = push_q && (!full || pop);

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            read_q    <= 1'b0;
            held_byte <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            // a same-cycle error event takes priority over the read-clear
            if (push_q && full && !pop) overflow <= 1'b1;
            else if (clear)             overflow <= 1'b0;
            if (frame_bad || timeout_hit) frame_err <= 1'b1;
            else if (clear)               frame_err <= 1'b0;
            read_q <= read;
            if (first) held_byte <= head_byte;
        end
    end

    // a held data read keeps showing the byte it popped on its first cycle
    assign head_byte   = not_empty ? mem[rd_ptr] : 8'h00;
    assign status_word = {48'b0, 8'(count), 4'b0, frame_err, overflow, full, not_empty};
    assign data_word   = {56'b0, read_q ? held_byte : head_byte};

    assign data = hit_status ? status_word : (hit_data ? data_word : {64{1'bz}});

endmodule

// File: tb/tb_kbd_ps2_port.sv
// Bench for kbd_ps2_port: PS/2 frames from a bit-level driver, bus reads checked every
// cycle against a queue-based register model, plus literal expectations from hand analysis.
module tb_kbd_ps2_port;

    localparam logic [63:0] BASE  = 64'h0000_0000_0000_2000;
    localparam int          DEPTH = 8;
    localparam int          FLEN  = 4;
    localparam int          TMO   = 300;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic        read     = 1'b0;
    logic [63:0] address  = '0;
    tri1  [63:0] data;     // released bus reads as all ones

    int vectors     = 0;
    int miscompares = 0;

    byte unsigned mq[$];
    bit           m_err, m_ovf, prev_rd;
    logic [7:0]   m_held;

    kbd_ps2_port #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .address(address), .read(read), .data(data)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [63:0] m_status();
        logic [63:0] s;
        s       = '0;
        s[15:8] = 8'(mq.size());
        s[3]    = m_err;
        s[2]    = m_ovf;
        s[1]    = (mq.size() == DEPTH);
        s[0]    = (mq.size() != 0);
        return s;
    endfunction

    function automatic logic [7:0] m_head();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else                   m_ovf = 1'b1;
    endtask

    // model-based check of the bus on every cycle out of reset
    always @(negedge clock) begin
        logic [63:0] want;
        bit          first;
        if (!reset) begin
            prev_rd = 1'b0;
        end else begin
            first = read && !prev_rd;
            if (read && address == BASE)             want = m_status();
            else if (read && address == BASE + 64'd8) want = {56'b0, first ? m_head() : m_held};
            else                                      want = '1;
            check("bus", data, want);
            if (first) begin
                m_held = m_head();
                if (address == BASE) begin
                    m_err = 1'b0;
                    m_ovf = 1'b0;
                end else if (address == BASE + 64'd8 && mq.size() != 0) begin
                    void'(mq.pop_front());
                end
            end
            prev_rd = read;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input bit b, input int half);
        ps2_data = b;
        tick(half);
        ps2_clk = 1'b0;
        tick(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int half);
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
        ps2_bit((~^b) ^ bad_par, half);
        ps2_bit(~bad_stop, half);
        ps2_data = 1'b1;
        tick(half + 8);
        if (bad_par || bad_stop) m_err = 1'b1;
        else                     m_push(b);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits, input int half,
                                input int hold);
        ps2_bit(1'b0, half);
        for (int i = 0; i < nbits; i++) ps2_bit((i < 8) ? b[i] : ~^b, half);
        ps2_data = 1'b1;
        tick(hold);
        m_err = 1'b1;
    endtask

    task automatic glitch(input int w);
        ps2_data = 1'b0;
        tick(2);
        ps2_clk = 1'b0;
        tick(w);
        ps2_clk = 1'b1;
        tick(8);
        ps2_data = 1'b1;
        tick(2);
    endtask

    task automatic rd(input logic [63:0] a, input int n, input bit lit,
                      input logic [63:0] want, input string nm);
        address = a;
        read    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (lit) check(nm, data, want);
            tick(1);
        end
        read    = 1'b0;
        address = '0;
        tick(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        tick(3);
        check("reset_bus", data, '1);
        reset = 1'b1;
        tick(2);
        rd(BASE, 1, 1, 64'h0, "reset_status");

        send_frame(8'h1C, 0, 0, 8);
        rd(BASE,       1, 1, 64'h0101, "1c_status");
        rd(BASE + 8,   1, 1, 64'h001C, "1c_data");
        rd(BASE,       1, 1, 64'h0000, "1c_status_after");

        send_frame(8'h1C, 1, 0, 8);
        rd(BASE, 1, 1, 64'h0008, "parity_status");
        rd(BASE, 1, 1, 64'h0000, "parity_cleared");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 8);
        rd(BASE, 1, 1, 64'h0807, "full_status");
        for (int i = 1; i <= 8; i++) rd(BASE + 8, 1, 1, 64'(i), "drain_order");
        rd(BASE + 8, 1, 1, 64'h0, "drain_empty");
        rd(BASE,     1, 1, 64'h0, "drain_status");

        send_partial(8'hA5, 4, 8, TMO + 2);
        rd(BASE, 1, 1, 64'h0008, "timeout_status");
        send_frame(8'hF0, 0, 0, 8);
        rd(BASE + 8, 1, 1, 64'h00F0, "after_timeout");

        send_frame(8'h1C, 0, 0, 8);
        send_frame(8'h32, 0, 0, 8);
        rd(BASE + 8, 3, 1, 64'h001C, "held_read");
        rd(BASE + 8, 1, 1, 64'h0032, "held_next");
        rd(BASE,     1, 1, 64'h0000, "held_status");

        glitch(1);
        glitch(2);
        rd(BASE, 1, 1, 64'h0000, "glitch_status");

        send_frame(8'h77, 0, 0, 8);
        ps2_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 8);
        ps2_data = 1'b0;
        tick(8);
        ps2_clk = 1'b0;
        tick(3);
        reset = 1'b0;
        mq.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        rd(BASE, 1, 1, 64'h0, "reset_mid_frame");
        tick(TMO + 10);
        send_frame(8'h5A, 0, 0, 8);
        rd(BASE + 8,  1, 1, 64'h005A, "after_reset");
        rd(BASE + 16, 1, 1, '1, "other_addr");

        repeat (60) begin
            int half;
            half = $urandom_range(6, 12);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_frame(8'($urandom), 0, 0, half);
                4:          send_frame(8'($urandom), 1, 0, half);
                5:          send_frame(8'($urandom), 0, 1, half);
                6:          rd(BASE, $urandom_range(1, 3), 0, '0, "");
                7:          rd(BASE + 8, $urandom_range(1, 3), 0, '0, "");
                8: begin
                    if ($urandom_range(0, 1) != 0) glitch($urandom_range(1, 2));
                    else rd(($urandom_range(0, 1) != 0) ? BASE + 4 : BASE + 16, 2, 0, '0, "");
                end
                default:    send_partial(8'($urandom), $urandom_range(0, 9), half, TMO + 4);
            endcase
        end
        for (int i = 0; i <= DEPTH; i++) rd(BASE + 8, 1, 0, '0, "");
        rd(BASE, 1, 0, '0, "");
        rd(BASE, 1, 1, 64'h0, "final_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
